// File: rtl/acc_result_collect.sv
// Result capture for the pipelined accumulator: aligns captures to the early ready flag,
// tags end-of-row results and buffers them in a FWFT FIFO. Optional: PIPE_RESULT_RELU_EN.
module acc_result_collect #(
  parameter int unsigned C_IN      = 13,
  parameter int unsigned C_CNT     = 16,
  parameter int unsigned C_DEPTH_W = 4
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [C_CNT-1:0] I_row_len,
  input  logic             I_result_rdy_pre4,
  input  logic [C_IN-1:0]  I_result,
  output logic             O_dout_valid,
  input  logic             I_dout_ready,
  output logic [C_IN-1:0]  O_dout,
  output logic             O_dout_last,
  output logic             O_fifo_afull,
  output logic             O_row_done,
  output logic             O_overflow
);

  localparam int unsigned DEPTH    = 2 ** C_DEPTH_W;
  localparam int unsigned OCC_W    = C_DEPTH_W + 1;
  localparam int unsigned AFULL_TH = DEPTH - 5;
  localparam int unsigned PIPE_N   = 4;

  typedef struct packed {
    logic            last;
    logic [C_IN-1:0] data;
  } entry_t;

  logic [PIPE_N-1:0]    flag_q, flag_d;
  logic [C_CNT-1:0]     cnt_q, cnt_d;
  logic [C_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 row_done_q, row_done_d;
  logic                 overflow_q, overflow_d;
  entry_t               mem_q [DEPTH];

  logic            capture_c;
  logic            last_c;
  logic            full_c;
  logic            empty_c;
  logic            rd_en_c;
  logic            wr_en_c;
  logic [C_IN-1:0] wr_data_c;
  entry_t          wr_entry_c;
  entry_t          head_c;

  assign capture_c = flag_q[PIPE_N-1];
  assign full_c    = (occ_q == OCC_W'(DEPTH));
  assign empty_c   = (occ_q == '0);
  assign rd_en_c   = !empty_c && I_dout_ready;
  assign wr_en_c   = capture_c && (!full_c || rd_en_c);

  // Row lengths of 0 and 1 both mean every result closes a row.
  assign last_c = (I_row_len <= C_CNT'(1)) || (cnt_q == (I_row_len - C_CNT'(1)));

`ifdef PIPE_RESULT_RELU_EN
  assign wr_data_c = I_result[C_IN-1] ? '0 : I_result;
`else
  assign wr_data_c = I_result;
`endif

  assign wr_entry_c.last = last_c;
  assign wr_entry_c.data = wr_data_c;

  // Next-state logic for the flag pipe, row counter, pointers and status flags.
  always_comb begin
    flag_d     = {flag_q[PIPE_N-2:0], I_result_rdy_pre4};
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    row_done_d = 1'b0;
    overflow_d = overflow_q;

    // Counter advances on every capture, dropped or not, to keep rows aligned.
    if (capture_c) begin
      row_done_d = last_c;
      cnt_d      = last_c ? '0 : (cnt_q + C_CNT'(1));
      if (!wr_en_c) begin
        overflow_d = 1'b1;
      end
    end

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + C_DEPTH_W'(1);
    end
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + C_DEPTH_W'(1);
    end

    unique case ({wr_en_c, rd_en_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      flag_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      row_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      row_done_q <= row_done_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: contents are only visible through a valid head.
  always_ff @(posedge I_clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign O_dout_valid = !empty_c;
  assign O_dout       = head_c.data;
  assign O_dout_last  = !empty_c && head_c.last;
  assign O_fifo_afull = (occ_q >= OCC_W'(AFULL_TH));
  assign O_row_done   = row_done_q;
  assign O_overflow   = overflow_q;

endmodule

// File: tb/tb_acc_result_collect.sv
// Self-checking bench for acc_result_collect: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_acc_result_collect;

  localparam int unsigned C_IN      = 13;
  localparam int unsigned C_CNT     = 16;
  localparam int unsigned C_DEPTH_W = 4;
  localparam int unsigned D         = 16;

  logic             I_clk;
  logic             I_rst;
  logic [C_CNT-1:0] I_row_len;
  logic             I_result_rdy_pre4;
  logic [C_IN-1:0]  I_result;
  logic             O_dout_valid;
  logic             I_dout_ready;
  logic [C_IN-1:0]  O_dout;
  logic             O_dout_last;
  logic             O_fifo_afull;
  logic             O_row_done;
  logic             O_overflow;

  acc_result_collect #(.C_IN(C_IN), .C_CNT(C_CNT), .C_DEPTH_W(C_DEPTH_W)) dut (
    .I_clk             (I_clk),
    .I_rst             (I_rst),
    .I_row_len         (I_row_len),
    .I_result_rdy_pre4 (I_result_rdy_pre4),
    .I_result          (I_result),
    .O_dout_valid      (O_dout_valid),
    .I_dout_ready      (I_dout_ready),
    .O_dout            (O_dout),
    .O_dout_last       (O_dout_last),
    .O_fifo_afull      (O_fifo_afull),
    .O_row_done        (O_row_done),
    .O_overflow        (O_overflow)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    bit              last;
    logic [C_IN-1:0] data;
  } exp_t;

  exp_t        fifo_m[$];
  int          flag_m[$];
  int unsigned row_len_m;
  int unsigned cnt_m;
  bit          ovf_m;
  bit          row_done_m;
  int          cyc;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit has = (fifo_m.size() != 0);
    chk("dout_valid", 32'(O_dout_valid), 32'(has));
    if (has) begin
      chk("dout", 32'(O_dout), 32'(fifo_m[0].data));
      chk("dout_last", 32'(O_dout_last), 32'(fifo_m[0].last));
    end else begin
      chk("dout_last_idle", 32'(O_dout_last), 32'd0);
    end
    chk("fifo_afull", 32'(O_fifo_afull), 32'(fifo_m.size() >= D - 5));
    chk("row_done", 32'(O_row_done), 32'(row_done_m));
    chk("overflow", 32'(O_overflow), 32'(ovf_m));
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model over the edge.
  task automatic step(input bit pre, input logic [C_IN-1:0] res, input bit rdy);
    bit   cap;
    bit   rd;
    bit   full;
    bit   lst;
    exp_t e;
    @(negedge I_clk);
    check_outputs();
    I_result_rdy_pre4 = pre;
    I_result          = res;
    I_dout_ready      = rdy;
    cap = 1'b0;
    if (flag_m.size() != 0 && flag_m[0] == cyc - 4) begin
      cap = 1'b1;
      void'(flag_m.pop_front());
    end
    if (pre) flag_m.push_back(cyc);
    rd   = (fifo_m.size() != 0) && rdy;
    full = (fifo_m.size() == D);
    row_done_m = 1'b0;
    lst = 1'b0;
    if (cap) begin
      lst = (row_len_m <= 1) || (cnt_m == row_len_m - 1);
      cnt_m = lst ? 0 : cnt_m + 1;
      row_done_m = lst;
    end
    if (rd) void'(fifo_m.pop_front());
    if (cap) begin
      if (!full || rd) begin
        e.last = lst;
`ifdef PIPE_RESULT_RELU_EN
        e.data = res[C_IN-1] ? '0 : res;
`else
        e.data = res;
`endif
        fifo_m.push_back(e);
      end else begin
        ovf_m = 1'b1;
      end
    end
    cyc++;
  endtask

  // Look at outputs just after the edge that ends the most recent step.
  task automatic peek_after_edge();
    @(posedge I_clk);
    #1;
  endtask

  task automatic rst_apply(input int unsigned rl);
    @(negedge I_clk);
    I_rst = 1'b1;
    I_result_rdy_pre4 = 1'b0;
    I_dout_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(O_dout_valid), 32'd0);
    chk("rst_last", 32'(O_dout_last), 32'd0);
    chk("rst_afull", 32'(O_fifo_afull), 32'd0);
    chk("rst_row_done", 32'(O_row_done), 32'd0);
    chk("rst_overflow", 32'(O_overflow), 32'd0);
    fifo_m.delete();
    flag_m.delete();
    cnt_m = 0;
    ovf_m = 1'b0;
    row_done_m = 1'b0;
    row_len_m = rl;
    I_row_len = C_CNT'(rl);
    @(negedge I_clk);
    @(negedge I_clk);
    I_rst = 1'b0;
  endtask

  initial begin
    logic [C_IN-1:0] v;
    checks = 0;
    failures = 0;
    cyc = 0;
    I_rst = 1'b1;
    I_row_len = '0;
    I_result_rdy_pre4 = 1'b0;
    I_result = '0;
    I_dout_ready = 1'b0;

    // Single result, row length 1.
    rst_apply(1);
    for (int i = 0; i < 10; i++) step(1'b0, C_IN'(0), 1'b0);
    step(1'b1, C_IN'(0), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, C_IN'(0), 1'b0);
    step(1'b0, 13'h0123, 1'b0);
    peek_after_edge();
    chk("single_dout", 32'(O_dout), 32'h0123);
    chk("single_last", 32'(O_dout_last), 32'd1);
    chk("single_row_done", 32'(O_row_done), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, C_IN'(0), 1'b1);

    // Burst of six with rows of three, consumer always ready.
    rst_apply(3);
    for (int k = 0; k < 10; k++) step(k < 6, (k >= 4) ? C_IN'(k - 3) : C_IN'(0), 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, C_IN'(0), 1'b1);

    // Fill to full with backpressure, then drop one.
    rst_apply(4);
    for (int k = 0; k < 17; k++) step(1'b1, C_IN'($urandom), 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, C_IN'($urandom), 1'b0);
    chk("full_afull", 32'(O_fifo_afull), 32'd1);
    chk("full_overflow", 32'(O_overflow), 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0, C_IN'(0), 1'b1);
    chk("overflow_sticky", 32'(O_overflow), 32'd1);

    // Full FIFO with a read in the capture cycle: the write is accepted.
    rst_apply(5);
    for (int k = 0; k < 17; k++) step(1'b1, C_IN'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, C_IN'($urandom), 1'b0);
    step(1'b0, C_IN'($urandom), 1'b1);
    peek_after_edge();
    chk("full_rw_overflow", 32'(O_overflow), 32'd0);
    chk("full_rw_afull", 32'(O_fifo_afull), 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0, C_IN'(0), 1'b1);

    // Negative and positive results.
    rst_apply(2);
    for (int k = 0; k < 6; k++) begin
      v = (k == 4) ? 13'h1FFF : ((k == 5) ? 13'h0005 : 13'h0000);
      step(k < 2, v, 1'b0);
      if (k == 4) begin
        peek_after_edge();
`ifdef PIPE_RESULT_RELU_EN
        chk("relu_neg", 32'(O_dout), 32'h0);
`else
        chk("relu_neg", 32'(O_dout), 32'h1FFF);
`endif
      end
    end
    for (int k = 0; k < 6; k++) step(1'b0, C_IN'(0), 1'b1);

    // Reset with three entries stored and two flags in flight.
    rst_apply(2);
    for (int k = 0; k < 7; k++) step(k < 3 || k == 5 || k == 6, C_IN'(k + 1), 1'b0);
    rst_apply(2);
    for (int k = 0; k < 8; k++) step(1'b0, C_IN'($urandom), 1'b1);

    // Randomized traffic with varying row lengths and consumer stalls.
    for (int r = 0; r < 8; r++) begin
      int unsigned pf;
      int unsigned pr;
      rst_apply($urandom_range(0, 5));
      pf = $urandom_range(30, 100);
      pr = $urandom_range(10, 100);
      for (int k = 0; k < 300; k++) begin
        step($urandom_range(0, 99) < pf, C_IN'($urandom), $urandom_range(0, 99) < pr);
      end
      for (int k = 0; k < 24; k++) step(1'b0, C_IN'(0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
